// File: rtl/next_pc_unit_pkg.sv
// next_pc_unit_pkg
// Shared definitions for the next-PC stage and its branch target buffer:
//   - RESET_PC_DEF : fetch address after reset (must equal the PC register reset)
//   - ctr_t        : 2-bit saturating direction counter encodings
//   - helpers      : counter saturation and BTB field-width derivation
package next_pc_unit_pkg;

  localparam int          IDX_W_DEF    = 4;
  localparam int          ENTRIES_DEF  = 1 << IDX_W_DEF;
  localparam logic [31:0] RESET_PC_DEF = 32'h3000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Tag covers everything above the index and the word-offset bits.
  function automatic int tag_w(input int idx_w);
    return 32 - idx_w - 2;
  endfunction

  function automatic ctr_t ctr_inc(input ctr_t c);
    case (c)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    case (c)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

endpackage

// File: rtl/next_pc_unit_btb_table.sv
// next_pc_unit_btb_table
// Direct-mapped BTB storage with 2-bit counters.
//   clk, rst                  : clock, synchronous active-high reset
//   lk_idx, lk_tag            : combinational lookup address fields
//   lk_hit, lk_ctr, lk_target : lookup result (pre-update contents)
//   upd_en, upd_idx, upd_tag  : training request from EX
//   upd_taken, upd_target     : resolved direction and taken target
module next_pc_unit_btb_table
  import next_pc_unit_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         lk_idx,
  input  logic [tag_w(IDX_W)-1:0]  lk_tag,
  output logic                     lk_hit,
  output ctr_t                     lk_ctr,
  output logic [31:0]              lk_target,
  input  logic                     upd_en,
  input  logic [IDX_W-1:0]         upd_idx,
  input  logic [tag_w(IDX_W)-1:0]  upd_tag,
  input  logic                     upd_taken,
  input  logic [31:0]              upd_target
);

  localparam int TAG_W = tag_w(IDX_W);

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];
  ctr_t             ctr_d    [ENTRIES];

  // Lookup reads the stored state directly, so a same-cycle update is not seen.
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_ctr    = ctr_q[lk_idx];
  assign lk_target = target_q[lk_idx];

  // Read-modify-write port: compute the replacement entry for upd_idx.
  logic             upd_hit;
  logic             upd_we;
  logic             new_valid;
  logic [TAG_W-1:0] new_tag;
  logic [31:0]      new_target;
  ctr_t             new_ctr;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    upd_we     = 1'b0;
    new_valid  = valid_q[upd_idx];
    new_tag    = tag_q[upd_idx];
    new_target = target_q[upd_idx];
    new_ctr    = ctr_q[upd_idx];
    if (upd_en) begin
      if (upd_taken) begin
        upd_we     = 1'b1;
        new_target = upd_target;
        if (upd_hit) begin
          new_ctr = ctr_inc(ctr_q[upd_idx]);
        end else begin
          // Allocation evicts whatever aliased into this slot.
          new_valid = 1'b1;
          new_tag   = upd_tag;
          new_ctr   = WT;
        end
      end else if (upd_hit) begin
        upd_we  = 1'b1;
        new_ctr = ctr_dec(ctr_q[upd_idx]);
      end
      // Not-taken miss: nothing worth remembering.
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
      if (upd_we && (upd_idx == IDX_W'(i))) begin
        valid_d[i]  = new_valid;
        tag_d[i]    = new_tag;
        target_d[i] = new_target;
        ctr_d[i]    = new_ctr;
      end
    end
  end

  // Only valid and ctr need reset; tag/target are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= valid_d[i];
        ctr_q[i]   <= ctr_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      tag_q[i]    <= tag_d[i];
      target_q[i] <= target_d[i];
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit
// Next fetch address generation ahead of the PC register.
//   clk, rst        : clock, synchronous active-high reset
//   c_pc            : current PC
//   hazard_stall    : hold fetch
//   ex_*            : branch resolution and redirect from EX
//   pc_en, n_pc     : PC register load enable and next address
//   pred_taken/_target : zero-latency prediction for c_pc
//   br_cnt, mp_cnt  : resolved-branch and mispredict counters (wrapping)
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int          ENTRIES  = ENTRIES_DEF,
  parameter int          IDX_W    = IDX_W_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c_pc,
  input  logic        hazard_stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_redirect_pc,
  output logic        pc_en,
  output logic [31:0] n_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] br_cnt,
  output logic [31:0] mp_cnt
);

  // The reset address lives in the PC register; kept here so both agree.
  logic [31:0] unused_reset_pc;
  logic [1:0]  unused_ex_lsb;
  assign unused_reset_pc = RESET_PC;
  assign unused_ex_lsb   = ex_pc[1:0];

  logic        lk_hit;
  ctr_t        lk_ctr;
  logic [31:0] lk_target;
  logic        upd_en;
  logic        redirect;
  logic [31:0] pc_plus4;

  assign upd_en   = ex_valid & ex_is_branch & ~rst;
  assign redirect = ex_valid & ex_mispredict;
  assign pc_plus4 = c_pc + 32'd4;

  next_pc_unit_btb_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lk_idx     (c_pc[IDX_W+1:2]),
    .lk_tag     (c_pc[31:IDX_W+2]),
    .lk_hit     (lk_hit),
    .lk_ctr     (lk_ctr),
    .lk_target  (lk_target),
    .upd_en     (upd_en),
    .upd_idx    (ex_pc[IDX_W+1:2]),
    .upd_tag    (ex_pc[31:IDX_W+2]),
    .upd_taken  (ex_taken),
    .upd_target (ex_target)
  );

  assign pred_taken  = ~rst & lk_hit & lk_ctr[1];
  assign pred_target = lk_hit ? lk_target : pc_plus4;
  // A redirect must win over a stall, otherwise the wrong path keeps fetching.
  assign pc_en       = ~rst & (~hazard_stall | redirect);

  always_comb begin
    n_pc = pc_plus4;
    if (redirect) begin
      n_pc = ex_redirect_pc;
    end else if (pred_taken) begin
      n_pc = pred_target;
    end
  end

  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q + {31'd0, upd_en};
    mp_cnt_d = mp_cnt_q + {31'd0, redirect};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= 32'd0;
      mp_cnt_q <= 32'd0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign br_cnt = br_cnt_q;
  assign mp_cnt = mp_cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed testbench for next_pc_unit. Inputs change on the falling edge,
// combinational outputs are checked 1 ns later, and state updates land on
// the following rising edge.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] c_pc;
  logic        hazard_stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
  logic        pc_en;
  logic [31:0] n_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .c_pc           (c_pc),
    .hazard_stall   (hazard_stall),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_mispredict  (ex_mispredict),
    .ex_redirect_pc (ex_redirect_pc),
    .pc_en          (pc_en),
    .n_pc           (n_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .br_cnt         (br_cnt),
    .mp_cnt         (mp_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus: applied at negedge, settled 1 ns later.
  task automatic drive(input logic r, input logic [31:0] pc, input logic stall,
                       input logic v, input logic b, input logic [31:0] epc,
                       input logic tk, input logic [31:0] tgt,
                       input logic mp, input logic [31:0] rpc);
    @(negedge clk);
    rst            = r;
    c_pc           = pc;
    hazard_stall   = stall;
    ex_valid       = v;
    ex_is_branch   = b;
    ex_pc          = epc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_mispredict  = mp;
    ex_redirect_pc = rpc;
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    drive(1'b0, pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] epc,
                       input logic tk, input logic [31:0] tgt);
    drive(1'b0, pc, 1'b0, 1'b1, 1'b1, epc, tk, tgt, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset: outputs quiet while rst is high.
    drive(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_pc_en", pc_en, 32'd0);
    chk("rst_pred", pred_taken, 32'd0);

    // Straight-line fetch from the reset address.
    idle(32'h3000);
    chk("seq_npc", n_pc, 32'h3004);
    chk("seq_pc_en", pc_en, 32'd1);
    chk("seq_pred", pred_taken, 32'd0);
    chk("seq_br_cnt", br_cnt, 32'd0);
    chk("seq_mp_cnt", mp_cnt, 32'd0);

    // Train taken branch at 3010 -> 3100 (allocates WT).
    train(32'h3004, 32'h3010, 1'b1, 32'h3100);
    chk("train_npc", n_pc, 32'h3008);

    idle(32'h3010);
    chk("hit_pred", pred_taken, 32'd1);
    chk("hit_target", pred_target, 32'h3100);
    chk("hit_npc", n_pc, 32'h3100);
    chk("br_cnt_1", br_cnt, 32'd1);

    // Same-cycle update is not bypassed: still sees WT, then drops to WNT.
    train(32'h3010, 32'h3010, 1'b0, 32'h0);
    chk("nobypass_pred", pred_taken, 32'd1);
    idle(32'h3010);
    chk("wnt_pred", pred_taken, 32'd0);
    chk("wnt_npc", n_pc, 32'h3014);

    // Upward saturation: WNT -T-> WT -T-> ST -T-> ST -N-> WT -N-> WNT.
    // Each check is the pre-update state of that cycle.
    train(32'h3010, 32'h3010, 1'b1, 32'h3100);
    chk("sat_u0", pred_taken, 32'd0);
    train(32'h3010, 32'h3010, 1'b1, 32'h3100);
    chk("sat_u1", pred_taken, 32'd1);
    train(32'h3010, 32'h3010, 1'b1, 32'h3100);
    chk("sat_u2", pred_taken, 32'd1);
    train(32'h3010, 32'h3010, 1'b0, 32'h0);
    chk("sat_u3_st", pred_taken, 32'd1);
    train(32'h3010, 32'h3010, 1'b0, 32'h0);
    chk("sat_u4_wt", pred_taken, 32'd1);
    // Downward saturation: WNT -N-> SNT -N-> SNT -T-> WNT -T-> WT.
    train(32'h3010, 32'h3010, 1'b0, 32'h0);
    chk("sat_d0", pred_taken, 32'd0);
    chk("sat_d0_npc", n_pc, 32'h3014);
    train(32'h3010, 32'h3010, 1'b0, 32'h0);
    chk("sat_d1", pred_taken, 32'd0);
    train(32'h3010, 32'h3010, 1'b1, 32'h3100);
    chk("sat_d2_snt", pred_taken, 32'd0);
    train(32'h3010, 32'h3010, 1'b1, 32'h3100);
    chk("sat_d3_wnt", pred_taken, 32'd0);
    idle(32'h3010);
    chk("sat_d4_wt", pred_taken, 32'd1);
    chk("br_cnt_11", br_cnt, 32'd11);

    // ex_valid low: no training, no count.
    drive(1'b0, 32'h3010, 1'b0, 1'b0, 1'b1, 32'h3010, 1'b0, 32'h0, 1'b1, 32'h3500);
    chk("inv_npc", n_pc, 32'h3100);
    chk("inv_pc_en", pc_en, 32'd1);
    idle(32'h3010);
    chk("inv_pred", pred_taken, 32'd1);
    chk("inv_br_cnt", br_cnt, 32'd11);
    chk("inv_mp_cnt", mp_cnt, 32'd0);

    // Alias: 3050 shares index 4 with 3010 and evicts it.
    train(32'h3000, 32'h3050, 1'b1, 32'h3300);
    idle(32'h3010);
    chk("alias_pred", pred_taken, 32'd0);
    chk("alias_npc", n_pc, 32'h3014);
    idle(32'h3050);
    chk("alias_new_npc", n_pc, 32'h3300);

    // Not-taken miss at another alias leaves the entry alone.
    train(32'h3000, 32'h3090, 1'b0, 32'h0);
    idle(32'h3050);
    chk("ntmiss_npc", n_pc, 32'h3300);
    idle(32'h3090);
    chk("ntmiss_pred", pred_taken, 32'd0);
    chk("br_cnt_13", br_cnt, 32'd13);

    // Stall alone holds the PC.
    drive(1'b0, 32'h3000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_pc_en", pc_en, 32'd0);

    // Mispredict during stall: redirect wins over prediction and stall.
    // A training update in the same stalled cycle still happens.
    drive(1'b0, 32'h3050, 1'b1, 1'b1, 1'b1, 32'h3020, 1'b1, 32'h3400, 1'b1, 32'h3200);
    chk("mp_pc_en", pc_en, 32'd1);
    chk("mp_npc", n_pc, 32'h3200);
    chk("mp_pred", pred_taken, 32'd1);
    idle(32'h3020);
    chk("mp_cnt_1", mp_cnt, 32'd1);
    chk("br_cnt_14", br_cnt, 32'd14);
    chk("stall_upd_npc", n_pc, 32'h3400);

    // PC increment wraps modulo 2^32.
    idle(32'hFFFF_FFFC);
    chk("wrap_npc", n_pc, 32'h0000_0000);

    // Mid-run reset with a pending taken update that must be discarded.
    drive(1'b1, 32'h3050, 1'b0, 1'b1, 1'b1, 32'h3060, 1'b1, 32'h3600, 1'b0, 32'h0);
    chk("mrst_pc_en", pc_en, 32'd0);
    chk("mrst_pred", pred_taken, 32'd0);
    idle(32'h3010);
    chk("mrst_3010", pred_taken, 32'd0);
    chk("mrst_npc", n_pc, 32'h3014);
    chk("mrst_br_cnt", br_cnt, 32'd0);
    chk("mrst_mp_cnt", mp_cnt, 32'd0);
    idle(32'h3050);
    chk("mrst_3050", pred_taken, 32'd0);
    idle(32'h3060);
    chk("mrst_3060", pred_taken, 32'd0);
    chk("mrst_3060_npc", n_pc, 32'h3064);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
